// File: rtl/uram_event_writein_sm.sv
// uram_event_writein_sm
// Write-side sequencer for the URAM event buffer. On an accepted trigger it
// emits four header words, then steps the 9-bit write address and the one-hot
// cascade-stage enable across NCASCADE*DEPTH sample beats, then commits the
// buffer to the reader. Buffer occupancy is tracked against the reader's
// complete_i flags.
// Optional feature: define WRITEIN_DROP_COUNT_EN to get a 16-bit saturating
// count of rejected triggers on dropped_count_o (tied to zero otherwise).
module uram_event_writein_sm #(
    parameter int NBUF     = 4,
    parameter int NCASCADE = 3,
    parameter int DEPTH    = 512
) (
    input  logic                         clk_i,
    input  logic                         rstb_i,
    input  logic                         trig_i,
    input  logic [47:0]                  trig_time_i,
    input  logic                         dat_valid_i,
    input  logic                         complete_i,
    output logic [31:0]                  header_dat_o,
    output logic                         header_wr_o,
    output logic [$clog2(NBUF)+9-1:0]    uram_addr_o,
    output logic [NCASCADE-1:0]          bram_we_o,
    output logic                         data_available_o,
    output logic                         full_o,
    output logic                         trig_dropped_o,
    output logic [15:0]                  dropped_count_o
);

    localparam int BW = $clog2(NBUF);

    // Occupancy thresholds; count needs one extra bit to represent NBUF itself.
    localparam logic [BW:0] CNT_FULL   = (BW+1)'(NBUF);
    localparam logic [BW:0] CNT_ALMOST = (BW+1)'(NBUF - 1);
    localparam logic [8:0]  ADDR_LAST  = 9'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_HDR2,
        S_HDR3,
        S_DATA,
        S_COMMIT
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           ev_num_q, ev_num_d;
    logic [47:0]           time_q, time_d;
    logic [BW-1:0]         wr_idx_q, wr_idx_d;
    logic [BW-1:0]         rd_idx_q, rd_idx_d;
    logic [BW:0]           count_q, count_d;
    logic [8:0]            addr9_q, addr9_d;
    logic [NCASCADE-1:0]   stage_q, stage_d;
    logic                  data_avail_q, data_avail_d;
    logic                  drop_q, drop_d;

    logic                  full_w;
    logic                  accept;
    logic                  beat;
    logic                  last_beat;
    logic                  commit;
    logic                  release_buf;

    // A buffer being filled counts toward fullness, so a fourth in-flight
    // event already blocks the next trigger.
    assign full_w = (count_q == CNT_FULL) ||
                    ((state_q != S_IDLE) && (count_q == CNT_ALMOST));

    assign accept      = (state_q == S_IDLE) && trig_i && !full_w;
    assign beat        = (state_q == S_DATA) && dat_valid_i;
    assign last_beat   = beat && (addr9_q == ADDR_LAST) && stage_q[NCASCADE-1];
    assign commit      = (state_q == S_COMMIT);
    // complete_i with nothing committed is ignored so count never underflows
    assign release_buf = complete_i && (count_q != '0);

    // State register
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_HDR0;
            S_HDR0:   state_d = S_HDR1;
            S_HDR1:   state_d = S_HDR2;
            S_HDR2:   state_d = S_HDR3;
            S_HDR3:   state_d = S_DATA;
            S_DATA:   if (last_beat) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output decode: header words, write strobes and address
    always_comb begin
        header_wr_o  = 1'b0;
        header_dat_o = 32'h0;
        bram_we_o    = '0;
        uram_addr_o  = {wr_idx_q, addr9_q};
        unique case (state_q)
            S_HDR0: begin
                header_wr_o  = 1'b1;
                header_dat_o = ev_num_q;
            end
            S_HDR1: begin
                header_wr_o  = 1'b1;
                header_dat_o = time_q[31:0];
            end
            S_HDR2: begin
                header_wr_o  = 1'b1;
                header_dat_o = {16'h0, time_q[47:32]};
            end
            S_HDR3: begin
                header_wr_o  = 1'b1;
                header_dat_o = {{(32-BW){1'b0}}, wr_idx_q};
            end
            S_DATA: begin
                if (dat_valid_i) bram_we_o = stage_q;
            end
            default: ;
        endcase
    end

    // Datapath next values: timestamp latch, address stepping, bookkeeping
    always_comb begin
        time_d      = time_q;
        addr9_d     = addr9_q;
        stage_d     = stage_q;
        ev_num_d    = ev_num_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        count_d     = count_q;
        drop_d      = trig_i && !accept;

        if (accept) begin
            time_d  = trig_time_i;
            addr9_d = 9'h0;
            stage_d = NCASCADE'(1);
        end

        // 9-bit address wraps naturally; the stage rotates on that wrap and
        // returns to stage 0 after the last beat of the event.
        if (beat) begin
            addr9_d = addr9_q + 9'd1;
            if (addr9_q == ADDR_LAST) begin
                stage_d = (stage_q << 1) | (stage_q >> (NCASCADE - 1));
            end
        end

        if (commit) begin
            ev_num_d = ev_num_q + 32'd1;
            wr_idx_d = wr_idx_q + BW'(1);
        end

        if (release_buf) begin
            rd_idx_d = rd_idx_q + BW'(1);
        end

        unique case ({commit, release_buf})
            2'b10:   count_d = count_q + (BW+1)'(1);
            2'b01:   count_d = count_q - (BW+1)'(1);
            default: count_d = count_q;
        endcase

        // Registered from the next count so data_available rises two cycles
        // after the final data beat.
        data_avail_d = (count_d != '0);
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            time_q       <= 48'h0;
            addr9_q      <= 9'h0;
            stage_q      <= NCASCADE'(1);
            ev_num_q     <= 32'h0;
            wr_idx_q     <= '0;
            rd_idx_q     <= '0;
            count_q      <= '0;
            data_avail_q <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            time_q       <= time_d;
            addr9_q      <= addr9_d;
            stage_q      <= stage_d;
            ev_num_q     <= ev_num_d;
            wr_idx_q     <= wr_idx_d;
            rd_idx_q     <= rd_idx_d;
            count_q      <= count_d;
            data_avail_q <= data_avail_d;
            drop_q       <= drop_d;
        end
    end

    assign full_o           = full_w;
    assign data_available_o = data_avail_q;
    assign trig_dropped_o   = drop_q;

`ifdef WRITEIN_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of rejected triggers, updated with the drop flag
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Drop counter register, cleared only by reset
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            drop_cnt_q <= 16'h0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign dropped_count_o = drop_cnt_q;
`else
    assign dropped_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_uram_event_writein_sm.sv
// Testbench for uram_event_writein_sm: directed steps, header and write
// scoreboards compared on every cycle, plus occupancy/drop/reset checks.
module tb_uram_event_writein_sm;

    localparam int NBUF     = 4;
    localparam int NCASCADE = 3;
    localparam int DEPTH    = 512;
    localparam int BW       = 2;
    localparam int AW       = BW + 9;
    localparam int BEATS    = NCASCADE * DEPTH;

    logic                clk = 1'b0;
    logic                rstb_i;
    logic                trig_i;
    logic [47:0]         trig_time_i;
    logic                dat_valid_i;
    logic                complete_i;
    logic [31:0]         header_dat_o;
    logic                header_wr_o;
    logic [AW-1:0]       uram_addr_o;
    logic [NCASCADE-1:0] bram_we_o;
    logic                data_available_o;
    logic                full_o;
    logic                trig_dropped_o;
    logic [15:0]         dropped_count_o;

    always #5 clk = ~clk;

    uram_event_writein_sm #(
        .NBUF(NBUF), .NCASCADE(NCASCADE), .DEPTH(DEPTH)
    ) dut (
        .clk_i            (clk),
        .rstb_i           (rstb_i),
        .trig_i           (trig_i),
        .trig_time_i      (trig_time_i),
        .dat_valid_i      (dat_valid_i),
        .complete_i       (complete_i),
        .header_dat_o     (header_dat_o),
        .header_wr_o      (header_wr_o),
        .uram_addr_o      (uram_addr_o),
        .bram_we_o        (bram_we_o),
        .data_available_o (data_available_o),
        .full_o           (full_o),
        .trig_dropped_o   (trig_dropped_o),
        .dropped_count_o  (dropped_count_o)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]            hdr_q[$];
    logic [AW+NCASCADE-1:0] wr_q[$];

    // Reference model state
    logic [31:0] m_ev;
    int          m_wr;
    int          m_count;
    int          m_drops;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_dc();
`ifdef WRITEIN_DROP_COUNT_EN
        return 16'(m_drops);
`else
        return 16'h0;
`endif
    endfunction

    // Compare DUT outputs of the current cycle against the scoreboards
    task automatic monitor();
        logic [31:0]            eh;
        logic [AW+NCASCADE-1:0] ew;
        if (header_wr_o === 1'b1) begin
            if (hdr_q.size() == 0) begin
                check("hdr_unexpected", 64'(header_wr_o), 64'h0);
            end else begin
                eh = hdr_q.pop_front();
                check("hdr_word", 64'(header_dat_o), 64'(eh));
            end
        end
        if (wr_q.size() != 0) begin
            ew = wr_q.pop_front();
            check("wr_addr_we", 64'({uram_addr_o, bram_we_o}), 64'(ew));
        end else begin
            check("we_idle", 64'(bram_we_o), 64'h0);
        end
    endtask

    // One clock: sample away from the edge, then advance to the next negedge
    task automatic cyc();
        #1;
        monitor();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_hdr_wr"}, 64'(header_wr_o), 64'h0);
        check({tag, "_hdr_dat"}, 64'(header_dat_o), 64'h0);
        check({tag, "_addr"}, 64'(uram_addr_o), 64'h0);
        check({tag, "_we"}, 64'(bram_we_o), 64'h0);
        check({tag, "_davail"}, 64'(data_available_o), 64'h0);
        check({tag, "_full"}, 64'(full_o), 64'h0);
        check({tag, "_drop"}, 64'(trig_dropped_o), 64'h0);
        check({tag, "_dropcnt"}, 64'(dropped_count_o), 64'h0);
    endtask

    task automatic model_reset();
        hdr_q.delete();
        wr_q.delete();
        m_ev    = 32'h0;
        m_wr    = 0;
        m_count = 0;
        m_drops = 0;
    endtask

    task automatic do_reset();
        rstb_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rstb_i = 1'b1;
        cyc();
    endtask

    // Full event: trigger, 4 header cycles, BEATS valid beats, commit
    task automatic run_event(input logic [47:0] t, input bit gaps, input bit cpl_at_commit);
        int          b;
        int          v;
        int          old_count;
        logic [AW-1:0] a;
        hdr_q.push_back(m_ev);
        hdr_q.push_back(t[31:0]);
        hdr_q.push_back({16'h0, t[47:32]});
        hdr_q.push_back(32'(m_wr));
        dat_valid_i = 1'b1;               // must be ignored outside DATA
        trig_i      = 1'b1;
        trig_time_i = t;
        cyc();
        trig_i      = 1'b0;
        trig_time_i = 48'h0;
        check("full_hdr0", 64'(full_o), 64'(m_count == NBUF - 1));
        repeat (4) cyc();
        b = 0;
        while (b < BEATS) begin
            v = gaps ? int'($urandom_range(0, 1)) : 1;
            if (v != 0) begin
                a = {BW'(m_wr), 9'(b % DEPTH)};
                wr_q.push_back({a, NCASCADE'(1 << (b / DEPTH))});
            end
            dat_valid_i = (v != 0);
            cyc();
            b += v;
        end
        dat_valid_i = 1'b0;
        // COMMIT cycle: data_available still reflects the old occupancy
        check("davail_commit", 64'(data_available_o), 64'(m_count != 0));
        old_count   = m_count;
        complete_i  = cpl_at_commit;
        cyc();
        complete_i  = 1'b0;
        m_ev        = m_ev + 32'd1;
        m_wr        = (m_wr + 1) % NBUF;
        if (!(cpl_at_commit && old_count != 0)) m_count = m_count + 1;
        check("davail_after", 64'(data_available_o), 64'(m_count != 0));
        check("count_full", 64'(full_o), 64'(m_count == NBUF));
        check("hdr_left", 64'(hdr_q.size()), 64'h0);
        check("wr_left", 64'(wr_q.size()), 64'h0);
        $display("event done: ev_num=%0d wr_idx=%0d count=%0d checks=%0d errors=%0d",
                 m_ev, m_wr, m_count, checks, errors);
    endtask

    initial begin
        rstb_i      = 1'b0;
        trig_i      = 1'b0;
        trig_time_i = 48'h0;
        dat_valid_i = 1'b0;
        complete_i  = 1'b0;
        @(negedge clk);

        // Test 1: reset state, single event with contiguous beats
        do_reset();
        run_event(48'h0000_1234_5678, 1'b0, 1'b0);

        // Test 2: valid beats with random gaps
        run_event(48'hABCD_9876_5432, 1'b1, 1'b0);

        // Test 3: fill all buffers, then a trigger is rejected
        do_reset();
        for (int e = 0; e < NBUF; e++) begin
            run_event(48'h0001_0000_0000 + 48'(e), 1'b0, 1'b0);
        end
        check("full_4", 64'(full_o), 64'h1);
        trig_i = 1'b1;
        trig_time_i = 48'hFFFF_FFFF_FFFF;
        cyc();
        trig_i = 1'b0;
        m_drops++;
        check("drop_full", 64'(trig_dropped_o), 64'h1);
        check("dropcnt_full", 64'(dropped_count_o), 64'(exp_dc()));
        cyc();
        check("drop_pulse_end", 64'(trig_dropped_o), 64'h0);
        $display("drop on full: dropped_count=%0d", dropped_count_o);

        // Test 4: drain to one, then complete coincident with commit
        for (int k = 0; k < NBUF - 1; k++) begin
            complete_i = 1'b1;
            cyc();
            complete_i = 1'b0;
            m_count--;
            check("drain_davail", 64'(data_available_o), 64'h1);
            check("drain_full", 64'(full_o), 64'h0);
            $display("complete: count=%0d", m_count);
        end
        run_event(48'h0000_0000_BEEF, 1'b0, 1'b1);
        check("cpl_commit_count1", 64'(m_count), 64'h1);

        // Test 5: trigger while busy, then async reset in the middle of DATA
        hdr_q.push_back(m_ev);
        hdr_q.push_back(32'h0000_7777);
        hdr_q.push_back(32'h0);
        hdr_q.push_back(32'(m_wr));
        trig_i = 1'b1;
        trig_time_i = 48'h0000_0000_7777;
        cyc();
        trig_i = 1'b0;
        repeat (4) cyc();
        for (int b = 0; b < 700; b++) begin
            logic [AW-1:0] a;
            a = {BW'(m_wr), 9'(b % DEPTH)};
            wr_q.push_back({a, NCASCADE'(1 << (b / DEPTH))});
            dat_valid_i = 1'b1;
            trig_i = (b == 300);
            cyc();
            if (b == 300) begin
                m_drops++;
                check("drop_busy", 64'(trig_dropped_o), 64'h1);
                check("dropcnt_busy", 64'(dropped_count_o), 64'(exp_dc()));
                $display("drop while busy: dropped_count=%0d", dropped_count_o);
            end
            if (b == 301) check("drop_busy_end", 64'(trig_dropped_o), 64'h0);
        end
        trig_i = 1'b0;
        dat_valid_i = 1'b1;
        rstb_i = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(negedge clk);
        dat_valid_i = 1'b0;
        cyc();
        rstb_i = 1'b1;
        cyc();
        complete_i = 1'b1;            // count is 0: must be ignored
        cyc();
        complete_i = 1'b0;
        cyc();
        check("cpl_empty_davail", 64'(data_available_o), 64'h0);
        check("cpl_empty_full", 64'(full_o), 64'h0);
        run_event(48'h0000_0000_0042, 1'b0, 1'b0);
        check("post_reset_dropcnt", 64'(dropped_count_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
